// File: rtl/tl_tx_fc_credit_gate_if.sv
// rtl/tl_tx_fc_credit_gate_if.sv - FC init/update, TLP request and credit status bundle
// master: DLL decode plus TX arbiter side; slave: the credit gate.
interface tl_tx_fc_credit_gate_if #(
   parameter int PAYLOAD_LENGTH  = 10,
   parameter int HDR_FIELD_SIZE  = 8,
   parameter int DATA_FIELD_SIZE = 12
);
   logic                        fc_init_valid;
   logic [HDR_FIELD_SIZE-1:0]   fc_init_hdr;
   logic [DATA_FIELD_SIZE-1:0]  fc_init_data;
   logic                        fc_update_valid;
   logic [HDR_FIELD_SIZE-1:0]   fc_update_hdr;
   logic [DATA_FIELD_SIZE-1:0]  fc_update_data;
   logic                        tlp_req_valid;
   logic                        tlp_req_has_data;
   logic [PAYLOAD_LENGTH-1:0]   tlp_req_length_dw;
   logic                        tlp_req_ready;
   logic                        fc_initialized;
   logic                        credit_blocked;
   logic [HDR_FIELD_SIZE-1:0]   hdr_credits_avail;
   logic [DATA_FIELD_SIZE-1:0]  data_credits_avail;

   modport master (
      output fc_init_valid, fc_init_hdr, fc_init_data,
      output fc_update_valid, fc_update_hdr, fc_update_data,
      output tlp_req_valid, tlp_req_has_data, tlp_req_length_dw,
      input  tlp_req_ready, fc_initialized, credit_blocked,
      input  hdr_credits_avail, data_credits_avail
   );

   modport slave (
      input  fc_init_valid, fc_init_hdr, fc_init_data,
      input  fc_update_valid, fc_update_hdr, fc_update_data,
      input  tlp_req_valid, tlp_req_has_data, tlp_req_length_dw,
      output tlp_req_ready, fc_initialized, credit_blocked,
      output hdr_credits_avail, data_credits_avail
   );
endinterface

// File: rtl/tl_tx_fc_credit_gate.sv
// rtl/tl_tx_fc_credit_gate.sv - TX flow-control credit gate for one credit type
// Tracks CREDIT_LIMIT / CREDITS_CONSUMED and grants a TLP only when the modulo gating rule allows it.
module tl_tx_fc_credit_gate #(
   parameter int PAYLOAD_LENGTH  = 10,
   parameter int HDR_FIELD_SIZE  = 8,
   parameter int DATA_FIELD_SIZE = 12
) (
   input  logic clk,
   input  logic arst_n,
   tl_tx_fc_credit_gate_if.slave bus
);
   localparam int HW         = HDR_FIELD_SIZE;
   localparam int DW         = DATA_FIELD_SIZE;
   localparam int GRAN_SHIFT = (DW == 16) ? 6 : ((DW == 14) ? 4 : 2);

   localparam logic [HW-1:0] HDR_HALF  = HW'(1) << (HW - 1);
   localparam logic [DW-1:0] DATA_HALF = DW'(1) << (DW - 1);
   localparam logic [DW-1:0] MAX_LEN   = DW'(1) << PAYLOAD_LENGTH;
   localparam logic [DW-1:0] GRAN_M1   = DW'((1 << GRAN_SHIFT) - 1);
   localparam logic [HW-1:0] HDR_ONE   = HW'(1);

   typedef enum logic {FC_IDLE, FC_ACTIVE} fc_state_t;

   fc_state_t     r_state;
   logic [HW-1:0] r_cl_hdr;
   logic [HW-1:0] r_cc_hdr;
   logic [DW-1:0] r_cl_data;
   logic [DW-1:0] r_cc_data;
   logic          r_hdr_inf;
   logic          r_data_inf;
   logic          r_fc_initialized;
   logic          r_credit_blocked;
   logic [HW-1:0] r_hdr_avail;
   logic [DW-1:0] r_data_avail;

   logic [DW-1:0] w_len_dw;
   logic [DW-1:0] w_p_data;
   logic [HW-1:0] w_hdr_rem;
   logic [DW-1:0] w_data_rem;
   logic          w_hdr_ok;
   logic          w_data_ok;
   logic          w_active;
   logic          w_ready;
   logic          w_fire;

   logic [HW-1:0] w_cl_hdr_nxt;
   logic [HW-1:0] w_cc_hdr_nxt;
   logic [DW-1:0] w_cl_data_nxt;
   logic [DW-1:0] w_cc_data_nxt;
   logic          w_hdr_inf_nxt;
   logic          w_data_inf_nxt;

   // Length 0 encodes the maximum payload; credits round up to the data granule.
   assign w_len_dw = (bus.tlp_req_length_dw == '0) ? MAX_LEN : DW'(bus.tlp_req_length_dw);
   assign w_p_data = bus.tlp_req_has_data ? ((w_len_dw + GRAN_M1) >> GRAN_SHIFT) : '0;

   assign w_hdr_rem  = r_cl_hdr - (r_cc_hdr + HDR_ONE);
   assign w_data_rem = r_cl_data - (r_cc_data + w_p_data);
   assign w_hdr_ok   = r_hdr_inf || (w_hdr_rem <= HDR_HALF);
   assign w_data_ok  = r_data_inf || (w_data_rem <= DATA_HALF);

   assign w_active = (r_state == FC_ACTIVE);
   assign w_ready  = w_active && w_hdr_ok && w_data_ok;
   assign w_fire   = bus.tlp_req_valid && w_ready;

   always_comb begin
      w_cl_hdr_nxt   = r_cl_hdr;
      w_cc_hdr_nxt   = r_cc_hdr;
      w_cl_data_nxt  = r_cl_data;
      w_cc_data_nxt  = r_cc_data;
      w_hdr_inf_nxt  = r_hdr_inf;
      w_data_inf_nxt = r_data_inf;
      if (!w_active) begin
         if (bus.fc_init_valid) begin
            w_cl_hdr_nxt   = bus.fc_init_hdr;
            w_cl_data_nxt  = bus.fc_init_data;
            w_cc_hdr_nxt   = '0;
            w_cc_data_nxt  = '0;
            w_hdr_inf_nxt  = (bus.fc_init_hdr == '0);
            w_data_inf_nxt = (bus.fc_init_data == '0);
         end
      end else begin
         // Grant was decided on the old limit; new limit and advanced count land together.
         if (bus.fc_update_valid && !r_hdr_inf) begin
            w_cl_hdr_nxt = bus.fc_update_hdr;
         end
         if (bus.fc_update_valid && !r_data_inf) begin
            w_cl_data_nxt = bus.fc_update_data;
         end
         if (w_fire && !r_hdr_inf) begin
            w_cc_hdr_nxt = r_cc_hdr + HDR_ONE;
         end
         if (w_fire && !r_data_inf) begin
            w_cc_data_nxt = r_cc_data + w_p_data;
         end
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_state          <= FC_IDLE;
         r_fc_initialized <= 1'b0;
         r_cl_hdr         <= '0;
         r_cc_hdr         <= '0;
         r_cl_data        <= '0;
         r_cc_data        <= '0;
         r_hdr_inf        <= 1'b0;
         r_data_inf       <= 1'b0;
         r_credit_blocked <= 1'b0;
         r_hdr_avail      <= '0;
         r_data_avail     <= '0;
      end else begin
         case (r_state)
            FC_IDLE: begin
               if (bus.fc_init_valid) begin
                  r_state          <= FC_ACTIVE;
                  r_fc_initialized <= 1'b1;
               end
            end
            FC_ACTIVE: begin
               r_state          <= FC_ACTIVE;
               r_fc_initialized <= 1'b1;
            end
            default: begin
               r_state          <= FC_IDLE;
               r_fc_initialized <= 1'b0;
            end
         endcase
         r_cl_hdr         <= w_cl_hdr_nxt;
         r_cc_hdr         <= w_cc_hdr_nxt;
         r_cl_data        <= w_cl_data_nxt;
         r_cc_data        <= w_cc_data_nxt;
         r_hdr_inf        <= w_hdr_inf_nxt;
         r_data_inf       <= w_data_inf_nxt;
         r_credit_blocked <= bus.tlp_req_valid && !w_ready && w_active;
         r_hdr_avail      <= w_hdr_inf_nxt ? '1 : (w_cl_hdr_nxt - w_cc_hdr_nxt);
         r_data_avail     <= w_data_inf_nxt ? '1 : (w_cl_data_nxt - w_cc_data_nxt);
      end
   end

   assign bus.tlp_req_ready      = w_ready;
   assign bus.fc_initialized     = r_fc_initialized;
   assign bus.credit_blocked     = r_credit_blocked;
   assign bus.hdr_credits_avail  = r_hdr_avail;
   assign bus.data_credits_avail = r_data_avail;
endmodule

// File: tb/tb_tl_tx_fc_credit_gate.sv
// tb/tb_tl_tx_fc_credit_gate.sv - scoreboard bench for tl_tx_fc_credit_gate
// Stimulus queues expected status snapshots and grants; a negedge monitor pops and compares.
module tb_tl_tx_fc_credit_gate;
   logic clk;
   logic arst_n;

   tl_tx_fc_credit_gate_if #(
      .PAYLOAD_LENGTH (10),
      .HDR_FIELD_SIZE (8),
      .DATA_FIELD_SIZE(12)
   ) bus_if ();

   tl_tx_fc_credit_gate #(
      .PAYLOAD_LENGTH (10),
      .HDR_FIELD_SIZE (8),
      .DATA_FIELD_SIZE(12)
   ) dut (
      .clk   (clk),
      .arst_n(arst_n),
      .bus   (bus_if)
   );

   typedef struct packed {
      logic [7:0]  hdr;
      logic [11:0] data;
      logic        blk;
      logic        init;
      logic        rdy;
      logic [15:0] id;
   } st_exp_t;

   typedef struct packed {
      logic        has_data;
      logic [9:0]  len;
      logic [15:0] id;
   } gr_exp_t;

   st_exp_t st_q[$];
   gr_exp_t gr_q[$];
   st_exp_t mon_st;
   gr_exp_t mon_gr;
   int      n_checks = 0;
   int      n_pass   = 0;
   int      st_id    = 0;
   int      gr_id    = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s #%0d actual=%0h required=%0h", name, id, act, exp);
   endtask

   always @(negedge clk) begin
      if (st_q.size() > 0) begin
         mon_st = st_q.pop_front();
         chk("hdr_avail",  32'(mon_st.id), 32'(bus_if.hdr_credits_avail),  32'(mon_st.hdr));
         chk("data_avail", 32'(mon_st.id), 32'(bus_if.data_credits_avail), 32'(mon_st.data));
         chk("blocked",    32'(mon_st.id), 32'(bus_if.credit_blocked),     32'(mon_st.blk));
         chk("init",       32'(mon_st.id), 32'(bus_if.fc_initialized),     32'(mon_st.init));
         chk("ready",      32'(mon_st.id), 32'(bus_if.tlp_req_ready),      32'(mon_st.rdy));
      end
      if (bus_if.tlp_req_valid && bus_if.tlp_req_ready) begin
         if (gr_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_grant actual=1 required=0");
         end else begin
            mon_gr = gr_q.pop_front();
            chk("grant_has_data", 32'(mon_gr.id), 32'(bus_if.tlp_req_has_data),  32'(mon_gr.has_data));
            chk("grant_len",      32'(mon_gr.id), 32'(bus_if.tlp_req_length_dw), 32'(mon_gr.len));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_st(input int h, input int d, input bit b, input bit i, input bit r);
      st_exp_t e;
      e.hdr  = 8'(h);
      e.data = 12'(d);
      e.blk  = b;
      e.init = i;
      e.rdy  = r;
      e.id   = 16'(st_id);
      st_id++;
      st_q.push_back(e);
   endtask

   task automatic exp_gr();
      gr_exp_t g;
      g.has_data = bus_if.tlp_req_has_data;
      g.len      = bus_if.tlp_req_length_dw;
      g.id       = 16'(gr_id);
      gr_id++;
      gr_q.push_back(g);
   endtask

   task automatic reset_and_init(input int h, input int d);
      arst_n = 1'b0;
      bus_if.tlp_req_valid = 1'b0;
      exp_st(0, 0, 0, 0, 0);
      cyc();
      arst_n = 1'b1;
      bus_if.fc_init_valid = 1'b1;
      bus_if.fc_init_hdr   = 8'(h);
      bus_if.fc_init_data  = 12'(d);
      cyc();
      bus_if.fc_init_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      arst_n = 1'b0;
      bus_if.fc_init_valid = 1'b0;
      bus_if.fc_init_hdr = '0;
      bus_if.fc_init_data = '0;
      bus_if.fc_update_valid = 1'b0;
      bus_if.fc_update_hdr = '0;
      bus_if.fc_update_data = '0;
      bus_if.tlp_req_valid = 1'b0;
      bus_if.tlp_req_has_data = 1'b0;
      bus_if.tlp_req_length_dw = '0;
      cyc();
      exp_st(0, 0, 0, 0, 0);
      cyc();
      arst_n = 1'b1;

      // request without InitFC is never granted
      bus_if.tlp_req_valid = 1'b1;
      exp_st(0, 0, 0, 0, 0);
      cyc();
      exp_st(0, 0, 0, 0, 0);
      cyc();
      bus_if.tlp_req_valid = 1'b0;
      bus_if.fc_init_valid = 1'b1;
      bus_if.fc_init_hdr   = 8'd2;
      bus_if.fc_init_data  = 12'd8;
      exp_st(0, 0, 0, 0, 0);
      cyc();
      bus_if.fc_init_valid = 1'b0;
      exp_st(2, 8, 0, 1, 1);
      cyc();

      // three header-only TLPs with two header credits
      bus_if.tlp_req_valid = 1'b1;
      exp_gr(); exp_st(2, 8, 0, 1, 1); cyc();
      exp_gr(); exp_st(1, 8, 0, 1, 1); cyc();
      exp_st(0, 8, 0, 1, 0); cyc();
      exp_st(0, 8, 1, 1, 0); cyc();
      bus_if.tlp_req_valid = 1'b0;
      exp_st(0, 8, 1, 1, 0); cyc();
      exp_st(0, 8, 0, 1, 0); cyc();

      // data credit rounding and a 1024 DW TLP waiting for an UpdateFC
      bus_if.fc_update_valid = 1'b1;
      bus_if.fc_update_hdr   = 8'd10;
      bus_if.fc_update_data  = 12'd8;
      exp_st(0, 8, 0, 1, 0); cyc();
      bus_if.fc_update_valid = 1'b0;
      exp_st(8, 8, 0, 1, 1); cyc();
      bus_if.tlp_req_valid     = 1'b1;
      bus_if.tlp_req_has_data  = 1'b1;
      bus_if.tlp_req_length_dw = 10'd5;
      exp_gr(); exp_st(8, 8, 0, 1, 1); cyc();
      bus_if.tlp_req_length_dw = 10'd0;
      exp_st(7, 6, 0, 1, 0); cyc();
      bus_if.fc_update_valid = 1'b1;
      bus_if.fc_update_hdr   = 8'd10;
      bus_if.fc_update_data  = 12'd264;
      exp_st(7, 6, 1, 1, 0); cyc();
      bus_if.fc_update_valid = 1'b0;
      exp_gr(); exp_st(7, 262, 1, 1, 1); cyc();
      bus_if.tlp_req_valid    = 1'b0;
      bus_if.tlp_req_has_data = 1'b0;
      exp_st(6, 6, 0, 1, 1); cyc();

      // header counter wrap-around: preload CC_hdr to 254 with CL tracking one ahead
      reset_and_init(2, 8);
      for (int i = 0; i < 254; i++) begin
         bus_if.tlp_req_valid   = 1'b1;
         bus_if.fc_update_valid = 1'b1;
         bus_if.fc_update_hdr   = 8'(i + 2);
         bus_if.fc_update_data  = 12'd8;
         exp_gr();
         cyc();
      end
      bus_if.fc_update_valid = 1'b0;
      bus_if.tlp_req_valid   = 1'b0;
      exp_st(1, 8, 0, 1, 1); cyc();
      bus_if.tlp_req_valid = 1'b1;
      exp_gr(); exp_st(1, 8, 0, 1, 1); cyc();
      bus_if.tlp_req_valid   = 1'b0;
      bus_if.fc_update_valid = 1'b1;
      bus_if.fc_update_hdr   = 8'd1;
      exp_st(0, 8, 0, 1, 0); cyc();
      bus_if.fc_update_valid = 1'b0;
      exp_st(2, 8, 0, 1, 1); cyc();
      bus_if.tlp_req_valid = 1'b1;
      exp_gr(); exp_st(2, 8, 0, 1, 1); cyc();
      exp_gr(); exp_st(1, 8, 0, 1, 1); cyc();
      exp_st(0, 8, 0, 1, 0); cyc();
      bus_if.tlp_req_valid = 1'b0;
      exp_st(0, 8, 1, 1, 0); cyc();
      exp_st(0, 8, 0, 1, 0); cyc();

      // infinite credits on both types
      reset_and_init(0, 0);
      exp_st(255, 4095, 0, 1, 1); cyc();
      bus_if.tlp_req_valid     = 1'b1;
      bus_if.tlp_req_has_data  = 1'b1;
      bus_if.tlp_req_length_dw = 10'd0;
      for (int i = 0; i < 6; i++) begin
         bus_if.fc_update_valid = (i == 2);
         bus_if.fc_update_hdr   = 8'd1;
         bus_if.fc_update_data  = 12'd1;
         exp_gr(); exp_st(255, 4095, 0, 1, 1); cyc();
      end
      bus_if.fc_update_valid  = 1'b0;
      bus_if.tlp_req_valid    = 1'b0;
      bus_if.tlp_req_has_data = 1'b0;
      exp_st(255, 4095, 0, 1, 1); cyc();

      // UpdateFC coincident with a grant at CL_hdr = CC_hdr + 1, then async reset
      reset_and_init(1, 8);
      bus_if.tlp_req_valid   = 1'b1;
      bus_if.fc_update_valid = 1'b1;
      bus_if.fc_update_hdr   = 8'd3;
      bus_if.fc_update_data  = 12'd8;
      exp_gr(); exp_st(1, 8, 0, 1, 1); cyc();
      bus_if.fc_update_valid = 1'b0;
      bus_if.tlp_req_valid   = 1'b0;
      exp_st(2, 8, 0, 1, 1); cyc();
      bus_if.tlp_req_valid = 1'b1;
      #2;
      arst_n = 1'b0;
      exp_st(0, 0, 0, 0, 0); cyc();
      arst_n = 1'b1;
      exp_st(0, 0, 0, 0, 0); cyc();
      exp_st(0, 0, 0, 0, 0); cyc();
      bus_if.tlp_req_valid = 1'b0;
      cyc();
      cyc();

      chk("status_queue_drained", 0, 32'(st_q.size()), 32'd0);
      chk("grant_queue_drained",  0, 32'(gr_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
